// File: rtl/riscv_defs_pkg.sv
// Shared RISC-V front-end definitions: XLEN, NOP encoding, default reset PC,
// and the packed {addr, inst} entry carried by the prefetch queue.
package riscv_defs_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous in-order queue; head is visible combinationally (0-cycle read).
// Latency: push visible at head the cycle after the push.
// Backpressure: none internally; the caller never pushes full or pops empty.
module prefetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign head = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/inst_prefetch.sv
// Instruction prefetch: issues sequential word fetches ahead of demand, queues returns in order.
// Latency: rvalid -> fetch_valid_o next cycle; same cycle when INST_PREFETCH_BYPASS_EN is defined.
// Backpressure: fetch_ready_i low fills the queue; requests stop once queued + live in-flight = DEPTH.
module inst_prefetch
    import riscv_defs_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            fetch_valid_o,
    output logic [XLEN-1:0] fetch_inst_o,
    output logic [XLEN-1:0] fetch_addr_o,
    input  logic            fetch_ready_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] flush_addr_i
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    // One extra bit: stale requests awaiting discard can stack behind a full window of new-path ones.
    localparam int unsigned IW = CW + 1;

    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [IW-1:0]   inflight;
    logic [IW-1:0]   inflight_nxt;
    logic [IW-1:0]   discard;
    logic [CW-1:0]   fifo_count;
    fetch_entry_t    head;
    fetch_entry_t    push_dat;
    logic            grant;
    logic            rsp;
    logic            keep;
    logic            byp;
    logic            queued;
    logic            fifo_push;
    logic            fifo_pop;

    assign mem_req_o  = !rst && ((IW'(fifo_count) + (inflight - discard)) < IW'(DEPTH));
    assign mem_addr_o = next_pc;

    assign grant  = mem_req_o && mem_gnt_i;
    // Responses with nothing outstanding belong to a pre-reset request and are ignored.
    assign rsp    = mem_rvalid_i && (inflight != '0);
    assign keep   = rsp && (discard == '0) && !flush_i;
    assign queued = (fifo_count != '0);

`ifdef INST_PREFETCH_BYPASS_EN
    assign byp = keep && !queued && fetch_ready_i;
`else
    assign byp = 1'b0;
`endif

    assign fifo_push    = keep && !byp;
    assign fifo_pop     = queued && !flush_i && fetch_ready_i;
    assign push_dat     = '{addr: rsp_pc, inst: mem_rdata_i};
    assign inflight_nxt = inflight + IW'(grant) - IW'(rsp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_pc  <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
        end else begin
            inflight <= inflight_nxt;
            if (flush_i) begin
                next_pc <= word_align(flush_addr_i);
                rsp_pc  <= word_align(flush_addr_i);
                discard <= inflight_nxt;
            end else begin
                if (grant) next_pc <= next_pc + 32'd4;
                if (keep)  rsp_pc  <= rsp_pc + 32'd4;
                if (rsp && (discard != '0)) discard <= discard - IW'(1);
            end
        end
    end

    prefetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_dat (push_dat),
        .pop      (fifo_pop),
        .flush    (flush_i),
        .count    (fifo_count),
        .head     (head)
    );

    always_comb begin
        fetch_valid_o = 1'b0;
        fetch_inst_o  = INST_NOP;
        fetch_addr_o  = '0;
        if (queued && !flush_i) begin
            fetch_valid_o = 1'b1;
            fetch_inst_o  = head.inst;
            fetch_addr_o  = head.addr;
        end else if (byp) begin
            fetch_valid_o = 1'b1;
            fetch_inst_o  = mem_rdata_i;
            fetch_addr_o  = rsp_pc;
        end
    end

endmodule

// File: tb/tb_inst_prefetch.sv
// Scoreboarded bench for inst_prefetch: directed phases push expected fetch
// addresses; a negedge monitor pops and compares every accepted instruction.
module tb_inst_prefetch;
    import riscv_defs_pkg::*;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef INST_PREFETCH_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        fetch_valid_o;
    logic [31:0] fetch_inst_o;
    logic [31:0] fetch_addr_o;
    logic        fetch_ready_i;
    logic        flush_i;
    logic [31:0] flush_addr_i;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    bit          resp_en;

    inst_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .fetch_valid_o (fetch_valid_o),
        .fetch_inst_o  (fetch_inst_o),
        .fetch_addr_o  (fetch_addr_o),
        .fetch_ready_i (fetch_ready_i),
        .flush_i       (flush_i),
        .flush_addr_i  (flush_addr_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic release_rst();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            next_cycle();
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    // In-order memory: grant in cycle N answers from cycle N+1, throttled by resp_en.
    initial begin
        logic [31:0] mq[$];
        bit          gnt_now;
        bit          rv_now;
        logic [31:0] gaddr;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        forever begin
            @(negedge clk);
            gnt_now = mem_req_o && mem_gnt_i;
            gaddr   = mem_addr_o;
            rv_now  = mem_rvalid_i;
            @(posedge clk);
            #2;
            if (rst) begin
                mq.delete();
            end else begin
                if (rv_now && mq.size() != 0) void'(mq.pop_front());
                if (gnt_now) mq.push_back(gaddr);
            end
            mem_rvalid_i = !rst && resp_en && (mq.size() != 0);
            mem_rdata_i  = mem_rvalid_i ? word_of(mq[0]) : 32'h0;
        end
    end

    always @(negedge clk) begin
        if (!rst && fetch_valid_o && fetch_ready_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got addr %h, required no output", fetch_addr_o);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("out_addr", fetch_addr_o, e);
                chk("out_inst", fetch_inst_o, word_of(e));
            end
        end
        if (!rst && dut.fifo_push && !dut.fifo_pop)
            chk("fifo_overflow", {31'b0, (dut.fifo_count >= 3'(DEPTH))}, 32'd0);
        if (!rst && mem_req_o)
            chk("addr_align", {30'b0, mem_addr_o[1:0]}, 32'd0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        mem_gnt_i = 1'b1;
        fetch_ready_i = 1'b1;
        flush_i = 1'b0;
        flush_addr_i = '0;
        resp_en = 1'b1;
        #3;
        chk("rst_req",   {31'b0, mem_req_o},     32'd0);
        chk("rst_addr",  mem_addr_o,             RESET_PC);
        chk("rst_valid", {31'b0, fetch_valid_o}, 32'd0);
        chk("rst_inst",  fetch_inst_o,           INST_NOP);
        chk("rst_faddr", fetch_addr_o,           32'd0);

        // Streaming with ready=1: eight back-to-back instructions.
        for (int a = 0; a < 32; a += 4) exp_q.push_back(32'(a));
        release_rst();
        @(negedge clk);
        chk("first_req",  {31'b0, mem_req_o}, 32'd1);
        chk("first_addr", mem_addr_o,         RESET_PC);
        for (int c = 1; c <= LAT + 8; c++) begin
            next_cycle();
            @(negedge clk);
            chk("stream_valid", {31'b0, fetch_valid_o}, {31'b0, (c >= LAT + 1)});
        end

        // Backpressure: queue fills with 0x20..0x2C, head held, requests stop.
        next_cycle();
        fetch_ready_i = 1'b0;
        repeat (6) next_cycle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'b0, fetch_valid_o}, 32'd1);
            chk("hold_addr",  fetch_addr_o,           32'h20);
            chk("hold_inst",  fetch_inst_o,           word_of(32'h20));
            chk("full_req",   {31'b0, mem_req_o},     32'd0);
            next_cycle();
        end
        exp_q.push_back(32'h20);
        fetch_ready_i = 1'b1;
        @(negedge clk);
        next_cycle();
        fetch_ready_i = 1'b0;
        @(negedge clk);
        chk("refill_req",  {31'b0, mem_req_o}, 32'd1);
        chk("refill_addr", mem_addr_o,         32'h30);
        next_cycle();
        @(negedge clk);
        chk("refill_once", {31'b0, mem_req_o}, 32'd0);
        next_cycle();
        next_cycle();

        // Asynchronous reset with a full queue.
        @(negedge clk);
        chk("pre_rst_valid", {31'b0, fetch_valid_o}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'b0, fetch_valid_o}, 32'd0);
        chk("arst_req",   {31'b0, mem_req_o},     32'd0);
        chk("arst_faddr", fetch_addr_o,           32'd0);
        chk("arst_inst",  fetch_inst_o,           INST_NOP);

        // Flush with two requests in flight and one queued word.
        fetch_ready_i = 1'b0;
        mem_gnt_i = 1'b1;
        resp_en = 1'b1;
        release_rst();
        @(negedge clk);
        chk("restart_req",  {31'b0, mem_req_o}, 32'd1);
        chk("restart_addr", mem_addr_o,         RESET_PC);
        next_cycle();
        next_cycle();
        resp_en = 1'b0;
        next_cycle();
        flush_i = 1'b1;
        flush_addr_i = 32'h0000_0102;
        mem_gnt_i = 1'b0;
        @(negedge clk);
        chk("flush_valid", {31'b0, fetch_valid_o}, 32'd0);
        next_cycle();
        flush_i = 1'b0;
        mem_gnt_i = 1'b1;
        resp_en = 1'b1;
        fetch_ready_i = 1'b1;
        for (int a = 0; a < 16; a += 4) exp_q.push_back(32'h100 + 32'(a));
        @(negedge clk);
        chk("redirect_req",  {31'b0, mem_req_o}, 32'd1);
        chk("redirect_addr", mem_addr_o,         32'h100);
        wait_drain("flush_drain");
        fetch_ready_i = 1'b0;

        // Grant stall: address 0x8 held for five cycles.
        @(negedge clk);
        #1;
        rst = 1'b1;
        fetch_ready_i = 1'b1;
        mem_gnt_i = 1'b1;
        resp_en = 1'b1;
        for (int a = 0; a < 20; a += 4) exp_q.push_back(32'(a));
        release_rst();
        next_cycle();
        next_cycle();
        mem_gnt_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_req",  {31'b0, mem_req_o}, 32'd1);
            chk("stall_addr", mem_addr_o,         32'h8);
            next_cycle();
        end
        mem_gnt_i = 1'b1;
        wait_drain("stall_drain");
        fetch_ready_i = 1'b0;

        // Address wrap through a flush to an unaligned target near the top.
        next_cycle();
        next_cycle();
        flush_i = 1'b1;
        flush_addr_i = 32'hFFFF_FFFB;
        fetch_ready_i = 1'b1;
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        @(negedge clk);
        chk("wrap_flush_valid", {31'b0, fetch_valid_o}, 32'd0);
        next_cycle();
        flush_i = 1'b0;
        @(negedge clk);
        chk("wrap_req",  {31'b0, mem_req_o}, 32'd1);
        chk("wrap_addr", mem_addr_o,         32'hFFFF_FFF8);
        wait_drain("wrap_drain");
        fetch_ready_i = 1'b0;
        repeat (3) next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
